// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Brief   : Shared types and constants for the sequential restoring divider.
// Revision: 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Step counter width; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : divisor_seq_if
// Brief   : start/busy/done handshake and operand/result bundle of the divider.
// Revision: 1.0 - initial release
// ============================================================================
interface divisor_seq_if import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Brief   : One restoring-division iteration: shift, trial subtract, restore.
// Revision: 1.0 - initial release
// ============================================================================
module div_step import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic [WIDTH:0]   p_in,
  input  wire logic             dbit,
  input  wire logic [WIDTH-1:0] divisor,
  output logic      [WIDTH:0]   p_out,
  output logic                  qbit
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  assign w_shift = {p_in[WIDTH-1:0], dbit};
  assign w_trial = w_shift - {1'b0, divisor};
  // A set P MSB means the true shifted value already exceeds any divisor.
  assign qbit    = ~w_trial[WIDTH] | p_in[WIDTH];
  assign p_out   = qbit ? w_trial : w_shift;
endmodule
`default_nettype wire

// File: rtl/divisor_seq.sv
`default_nettype none
// ============================================================================
// Module  : divisor_seq
// Brief   : Sequential restoring divider, one quotient bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
module divisor_seq import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  divisor_seq_if.slave bus
);
  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [0:0]    ST_IDLE  = IDLE;
  localparam logic [0:0]    ST_CALC  = CALC;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic             r_zpend;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_p_next;
  logic             w_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_in    (r_p),
    .dbit    (r_q[WIDTH-1]),
    .divisor (r_divisor),
    .p_out   (w_p_next),
    .qbit    (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_p       <= '0;
      r_q       <= '0;
      r_divisor <= '0;
      r_zpend   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A zero divisor finishes one cycle after acceptance without CALC.
          if (r_zpend) begin
            r_zpend <= 1'b0;
            r_quot  <= '1;
            r_rem   <= r_q;
            r_dbz   <= 1'b1;
            r_done  <= 1'b1;
          end else if (bus.start) begin
            r_q       <= bus.dividend;
            r_divisor <= bus.divisor;
            r_p       <= '0;
            r_count   <= CNT_INIT;
            if (bus.divisor != '0) begin
              r_busy  <= 1'b1;
              r_state <= ST_CALC;
            end else begin
              r_zpend <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          r_p     <= w_p_next;
          r_q     <= {r_q[WIDTH-2:0], w_qbit};
          r_count <= r_count - 1'b1;
          if (r_count == '0) begin
            r_quot  <= {r_q[WIDTH-2:0], w_qbit};
            r_rem   <= w_p_next[WIDTH-1:0];
            r_dbz   <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire

// File: tb/tb_divisor_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_divisor_seq
// Brief   : Self-checking bench for divisor_seq against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_divisor_seq;
  localparam int W   = 5;
  localparam int TMO = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  divisor_seq_if #(.WIDTH(W)) bus ();

  divisor_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; the next edge accepts the request.
  task automatic launch(input int a, input int b);
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
  endtask

  // Waits for done and checks results; optionally pulses a stray start mid-op.
  task automatic finish_op(input int a, input int b, input bit hold, input int pulse_at,
                           input string tag);
    int  exp_q, exp_r, exp_z, exp_lat, cyc, busy_cyc;
    bit  seen;
    if (b == 0) begin
      exp_q = (1 << W) - 1; exp_r = a; exp_z = 1; exp_lat = 1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_z = 0; exp_lat = W;
    end
    cyc = 0; seen = 1'b0;
    busy_cyc = int'(bus.busy);
    while (!seen && cyc < TMO) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) seen = 1'b1;
      else busy_cyc += int'(bus.busy);
      if (cyc == pulse_at) begin
        bus.start = 1'b1; bus.dividend = W'(9); bus.divisor = W'(2);
      end else if (cyc == pulse_at + 1) begin
        bus.start = 1'b0;
      end
    end
    chk($sformatf("%s latency", tag), cyc, exp_lat);
    chk($sformatf("%s busy cycles", tag), busy_cyc, (b == 0) ? 0 : W);
    chk($sformatf("%s busy at done", tag), bus.busy, 0);
    chk($sformatf("%s quotient", tag), bus.quotient, exp_q);
    chk($sformatf("%s remainder", tag), bus.remainder, exp_r);
    chk($sformatf("%s div_by_zero", tag), bus.div_by_zero, exp_z);
    if (b != 0) begin
      chk($sformatf("%s q*d+r", tag), int'(bus.quotient) * b + int'(bus.remainder), a);
      chk($sformatf("%s r<d", tag), 32'(int'(bus.remainder) < b), 1);
    end
    if (hold) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s done pulse width", tag), bus.done, 0);
      chk($sformatf("%s quotient hold", tag), bus.quotient, exp_q);
      chk($sformatf("%s remainder hold", tag), bus.remainder, exp_r);
    end
  endtask

  initial begin
    int a, b, dones;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #2 rst_n = 1'b0;
    #21;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset quotient", bus.quotient, 0);
    chk("reset remainder", bus.remainder, 0);
    chk("reset div_by_zero", bus.div_by_zero, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    launch(27, 5); finish_op(27, 5, 1, -1, "27/5");
    launch(31, 1); finish_op(31, 1, 1, -1, "31/1");
    launch(3, 7);  finish_op(3, 7, 1, -1, "3/7");
    launch(31, 31); finish_op(31, 31, 1, -1, "31/31");
    launch(13, 0); finish_op(13, 0, 1, -1, "13/0");
    launch(10, 3); finish_op(10, 3, 1, -1, "10/3");

    // Stray start while busy is ignored; start in the done cycle is accepted.
    launch(20, 6); finish_op(20, 6, 0, 1, "20/6 ignore");
    launch(9, 2);  finish_op(9, 2, 1, -1, "9/2 b2b");

    // Asynchronous reset between edges in the middle of CALC.
    launch(27, 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset busy", bus.busy, 0);
    chk("midreset done", bus.done, 0);
    chk("midreset quotient", bus.quotient, 0);
    chk("midreset remainder", bus.remainder, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    repeat (W + 3) begin
      @(posedge clk);
      #1;
      dones += int'(bus.done);
    end
    chk("no done after reset", dones, 0);
    launch(27, 5); finish_op(27, 5, 1, -1, "27/5 after reset");

    // Every operand pair, back to back, with operand noise after acceptance.
    for (int i = 0; i < (1 << W) * (1 << W); i++) begin
      a = i >> W;
      b = i & ((1 << W) - 1);
      launch(a, b);
      finish_op(a, b, 0, -1, $sformatf("sweep %0d/%0d", a, b));
    end

    // Random operands with random idle gaps.
    repeat (100) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      a = $urandom_range(0, (1 << W) - 1);
      b = $urandom_range(0, (1 << W) - 1);
      launch(a, b);
      finish_op(a, b, $urandom_range(0, 1), -1, $sformatf("rand %0d/%0d", a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
